// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants and load/store unit types
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the load lane and sign/zero extends it
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      a,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata[7:0];
    case (a)
      2'b00:   byte_v = rdata[7:0];
      2'b01:   byte_v = rdata[15:8];
      2'b10:   byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = a[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      F3_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - MEM-stage load/store unit driving a valid/ready data bus
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            MemReqM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] AddrM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallLSU,
  output logic            FaultM,
  output logic            dreq_valid,
  input  logic            dreq_ready,
  output logic            dreq_we,
  output logic [XLEN-1:0] dreq_addr,
  output logic [3:0]      dreq_be,
  output logic [XLEN-1:0] dreq_wdata,
  input  logic            drsp_valid,
  input  logic [XLEN-1:0] drsp_rdata
);

  lsu_state_e      state_q;
  logic            valid_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic [1:0]      a_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] load_data;

  logic            illegal;
  logic            misalign;
  logic            fault;
  logic [3:0]      be_n;
  logic [XLEN-1:0] wdata_n;

  // Funct3M[1:0] encodes access size for both loads and stores.
  always_comb begin
    illegal  = (Funct3M == 3'b011) || (Funct3M[2:1] == 2'b11);
    misalign = ((Funct3M[1:0] == 2'b01) && AddrM[0]) ||
               ((Funct3M[1:0] == 2'b10) && (AddrM[1:0] != 2'b00));
    fault    = illegal || misalign;
  end

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = '0;
    if (MemWriteM) begin
      case (Funct3M[1:0])
        2'b00: begin
          be_n    = 4'b0001 << AddrM[1:0];
          wdata_n = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_n    = 4'b0011 << AddrM[1:0];
          wdata_n = {2{WriteDataM[15:0]}};
        end
        default: begin
          be_n    = 4'b1111;
          wdata_n = WriteDataM;
        end
      endcase
    end
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .funct3 (f3_q),
    .a      (a_q),
    .rdata  (drsp_rdata),
    .data   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LSU_IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (MemReqM && !fault) begin
            valid_q <= 1'b1;
            we_q    <= MemWriteM;
            addr_q  <= {AddrM[XLEN-1:2], 2'b00};
            be_q    <= be_n;
            wdata_q <= wdata_n;
            f3_q    <= Funct3M;
            a_q     <= AddrM[1:0];
            state_q <= LSU_REQ;
          end
        end
        LSU_REQ: begin
          if (dreq_ready) begin
            valid_q <= 1'b0;
            state_q <= LSU_WAIT;
          end
        end
        LSU_WAIT: begin
          if (drsp_valid) begin
            rdata_q <= we_q ? '0 : load_data;
            state_q <= LSU_DONE;
          end
        end
        // DONE always releases so the instruction is never reissued.
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  always_comb begin
    StallLSU = 1'b0;
    case (state_q)
      LSU_IDLE: StallLSU = MemReqM && !fault;
      LSU_REQ:  StallLSU = 1'b1;
      LSU_WAIT: StallLSU = 1'b1;
      default:  StallLSU = 1'b0;
    endcase
  end

  assign FaultM     = (state_q == LSU_IDLE) && MemReqM && fault;
  assign ReadDataM  = (state_q == LSU_DONE) ? rdata_q : '0;
  assign dreq_valid = valid_q;
  assign dreq_we    = we_q;
  assign dreq_addr  = addr_q;
  assign dreq_be    = be_q;
  assign dreq_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReqM;
  logic        MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] AddrM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallLSU;
  logic        FaultM;
  logic        dreq_valid;
  logic        dreq_ready;
  logic        dreq_we;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_be;
  logic [31:0] dreq_wdata;
  logic        drsp_valid;
  logic [31:0] drsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReqM    (MemReqM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallLSU   (StallLSU),
    .FaultM     (FaultM),
    .dreq_valid (dreq_valid),
    .dreq_ready (dreq_ready),
    .dreq_we    (dreq_we),
    .dreq_addr  (dreq_addr),
    .dreq_be    (dreq_be),
    .dreq_wdata (dreq_wdata),
    .drsp_valid (drsp_valid),
    .drsp_rdata (drsp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one access, acts as the bus (ready after rdly REQ cycles, response next cycle).
  task automatic run_access(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          rdly,
    output int          stalls,
    output int          accepts,
    output logic [31:0] rdo,
    output logic [31:0] q_addr,
    output logic [3:0]  q_be,
    output logic [31:0] q_wdata,
    output logic        q_we,
    output logic        unstable
  );
    bit done, seen, pend;
    int waited;
    stalls = 0; accepts = 0; rdo = '0; q_addr = '0; q_be = '0; q_wdata = '0; q_we = 1'b0;
    unstable = 1'b0; done = 0; seen = 0; pend = 0; waited = 0;
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = we; Funct3M = f3; AddrM = addr; WriteDataM = wd;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk);
      drsp_valid = pend; drsp_rdata = rd; pend = 0; dreq_ready = 1'b0;
      #1;
      if (!StallLSU) begin
        rdo  = ReadDataM;
        done = 1;
      end else begin
        stalls++;
        if (dreq_valid) begin
          if (!seen) begin
            q_addr = dreq_addr; q_be = dreq_be; q_wdata = dreq_wdata; q_we = dreq_we;
            seen = 1;
          end else if (dreq_addr !== q_addr || dreq_be !== q_be ||
                       dreq_wdata !== q_wdata || dreq_we !== q_we) begin
            unstable = 1'b1;
          end
          if (waited >= rdly) begin
            dreq_ready = 1'b1;
            accepts++;
            pend = 1;
          end else begin
            waited++;
          end
        end
      end
    end
    check("access_done", 32'(done), 32'd1);
    @(negedge clk);
    MemReqM = 1'b0; drsp_valid = 1'b0; dreq_ready = 1'b0;
    #1;
    check("no_reissue", 32'(dreq_valid), 32'd0);
  endtask

  int          st, acc;
  logic [31:0] rdo, qa, qw;
  logic [3:0]  qb;
  logic        qwe, unst;

  initial begin
    rst_n = 1'b0; MemReqM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000; AddrM = '0;
    WriteDataM = '0; dreq_ready = 1'b0; drsp_valid = 1'b0; drsp_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_stall", 32'(StallLSU), 32'd0);
    check("rst_fault", 32'(FaultM), 32'd0);
    check("rst_valid", 32'(dreq_valid), 32'd0);
    check("rst_addr",  dreq_addr, 32'h0);
    check("rst_be",    32'(dreq_be), 32'h0);
    check("rst_wdata", dreq_wdata, 32'h0);
    check("rst_we",    32'(dreq_we), 32'd0);
    rst_n = 1'b1;

    // LW aligned
    run_access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lw_addr",   qa, 32'h100);
    check("lw_be",     32'(qb), 32'hF);
    check("lw_we",     32'(qwe), 32'd0);
    check("lw_stalls", 32'(st), 32'd3);
    check("lw_acc",    32'(acc), 32'd1);
    check("lw_data",   rdo, 32'hDEADBEEF);

    run_access(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lb_addr", qa, 32'h100);
    check("lb_data", rdo, 32'hFFFFFF80);
    run_access(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lbu_data", rdo, 32'h00000080);
    run_access(1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lhu_data", rdo, 32'h000080FF);
    run_access(1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lh_data", rdo, 32'hFFFF80FF);
    run_access(1'b0, 3'b000, 32'h101, 32'h0, 32'h80FF1234, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("lb1_data", rdo, 32'h00000012);

    // Stores
    run_access(1'b1, 3'b000, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("sb_we",    32'(qwe), 32'd1);
    check("sb_addr",  qa, 32'h200);
    check("sb_be",    32'(qb), 32'h2);
    check("sb_wdata", qw, 32'hA5A5A5A5);
    check("sb_rdata", rdo, 32'h0);
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("sh_be",    32'(qb), 32'hC);
    check("sh_wdata", qw, 32'hABCDABCD);
    run_access(1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("sw_addr",  qa, 32'h204);
    check("sw_be",    32'(qb), 32'hF);
    check("sw_wdata", qw, 32'hCAFEF00D);

    // Backpressure: ready held low for 3 REQ cycles
    run_access(1'b1, 3'b000, 32'h302, 32'h0000005A, 32'h0, 3, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("bp_stalls", 32'(st), 32'd6);
    check("bp_acc",    32'(acc), 32'd1);
    check("bp_stable", 32'(unst), 32'd0);
    check("bp_be",     32'(qb), 32'h4);
    check("bp_wdata",  qw, 32'h5A5A5A5A);

    // Faults
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b001; AddrM = 32'h101;
    #1;
    check("mis_fault", 32'(FaultM), 32'd1);
    check("mis_stall", 32'(StallLSU), 32'd0);
    check("mis_rdata", ReadDataM, 32'h0);
    @(negedge clk);
    #1;
    check("mis_valid", 32'(dreq_valid), 32'd0);
    Funct3M = 3'b011; AddrM = 32'h100;
    #1;
    check("ill_fault", 32'(FaultM), 32'd1);
    check("ill_stall", 32'(StallLSU), 32'd0);
    MemWriteM = 1'b1; Funct3M = 3'b010; AddrM = 32'h102;
    #1;
    check("sw_mis_fault", 32'(FaultM), 32'd1);
    @(negedge clk);
    #1;
    check("ill_valid", 32'(dreq_valid), 32'd0);
    MemReqM = 1'b0;

    // Reset while waiting for the response
    @(negedge clk);
    MemReqM = 1'b1; MemWriteM = 1'b0; Funct3M = 3'b010; AddrM = 32'h300;
    @(negedge clk);
    MemReqM = 1'b0;
    #1;
    check("rw_req_valid", 32'(dreq_valid), 32'd1);
    dreq_ready = 1'b1;
    @(negedge clk);
    dreq_ready = 1'b0;
    #1;
    check("rw_wait_stall", 32'(StallLSU), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rw_rst_stall", 32'(StallLSU), 32'd0);
    check("rw_rst_addr", dreq_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drsp_valid = 1'b1; drsp_rdata = 32'h12345678;
    #1;
    check("rw_rsp_stall", 32'(StallLSU), 32'd0);
    check("rw_rsp_rdata", ReadDataM, 32'h0);
    @(negedge clk);
    drsp_valid = 1'b0;
    #1;
    check("rw_after_rdata", ReadDataM, 32'h0);
    check("rw_after_valid", 32'(dreq_valid), 32'd0);
    run_access(1'b0, 3'b010, 32'h104, 32'h0, 32'h0BADF00D, 0, st, acc, rdo, qa, qb, qw, qwe, unst);
    check("rw_lw_addr",   qa, 32'h104);
    check("rw_lw_stalls", 32'(st), 32'd3);
    check("rw_lw_data",   rdo, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
